// File: rtl/lane_accum_pkg.sv
// lane_accum_pkg
//   Shared definitions for the lane accumulator array: lane and datapath
//   widths, the opcode enum, and bit positions of every field on the flat
//   stimulus (in_flat) and result (out_flat) buses.
package lane_accum_pkg;

    localparam int LANES = 8;
    localparam int DW    = 32;
    localparam int AW    = 40;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_XOR   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_SHADD = 3'd6,
        OP_HOLD  = 3'd7
    } op_e;

    // in_flat layout
    localparam int IN_OP_LSB  = LANES * DW;      // 256
    localparam int IN_EN_LSB  = IN_OP_LSB + 3;   // 259
    localparam int IN_SH_LSB  = IN_EN_LSB + LANES; // 267
    localparam int IN_CLR_BIT = IN_SH_LSB + 3;   // 270
    localparam int IN_W       = IN_CLR_BIT + 1;  // 271

    // out_flat layout
    localparam int OUT_OVF_LSB = LANES * AW;         // 320
    localparam int OUT_NZ_BIT  = OUT_OVF_LSB + LANES; // 328
    localparam int OUT_PAR_BIT = OUT_NZ_BIT + 1;     // 329
    localparam int OUT_W       = OUT_PAR_BIT + 1;    // 330

endpackage

// File: rtl/lane_accum_cell.sv
// lane_accum_cell
//   One accumulator lane: 40-bit accumulator plus sticky signed-overflow flag.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     a            32-bit lane operand
//     op           shared opcode
//     en           lane enable (hold when low)
//     shamt        shift amount for SHADD
//     clr          synchronous clear of acc and ovf, overrides everything
//     acc, ovf     registered accumulator and overflow flag
module lane_accum_cell
    import lane_accum_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  op_e           op,
    input  logic          en,
    input  logic [2:0]    shamt,
    input  logic          clr,
    output logic [AW-1:0] acc,
    output logic          ovf
);

    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;

    logic [AW-1:0] sx, zx, addend, sum;
    logic          sum_ovf;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can leave a value unassigned and
    // infer a latch.
    always_comb begin
        sx = {{(AW-DW){a[DW-1]}}, a};
        zx = {{(AW-DW){1'b0}}, a};

        // ADD, SUB and SHADD share one adder; only the second input differs.
        // Negating a sign-extended 32-bit value never wraps in 40 bits.
        unique case (op)
            OP_SUB:   addend = -sx;
            OP_SHADD: addend = sx << shamt;
            default:  addend = sx;
        endcase

        sum     = acc_q + addend;
        sum_ovf = (acc_q[AW-1] == addend[AW-1]) && (sum[AW-1] != acc_q[AW-1]);

        acc_d = acc_q;
        ovf_d = ovf_q;

        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en) begin
            case (op)
                OP_ADD, OP_SUB, OP_SHADD: begin
                    acc_d = sum;
                    ovf_d = ovf_q | sum_ovf;   // sticky; only clr/reset clear it
                end
                OP_XOR:  acc_d = acc_q ^ zx;
                OP_LOAD: acc_d = sx;
                OP_AND:  acc_d = acc_q & zx;
                OP_OR:   acc_d = acc_q | zx;
                OP_HOLD: acc_d = acc_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value; the async reset gives each one a defined
    // value so nothing X ever reaches the output bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/lane_accum_array.sv
// lane_accum_array
//   Eight-lane registered accumulator array behind flat buses.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     in_flat     [32i+31:32i] a_i, [258:256] op, [266:259] en,
//                 [269:267] shamt, [270] clr
//     out_flat    [40i+39:40i] acc_i, [327:320] ovf, [328] any_nz, [329] par
//   any_nz and par are reduced combinationally from the lane registers.
module lane_accum_array
    import lane_accum_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_flat,
    output logic [OUT_W-1:0] out_flat
);

    op_e              op;
    logic [LANES-1:0] en;
    logic [2:0]       shamt;
    logic             clr;

    logic [LANES*AW-1:0] acc_all;
    logic [LANES-1:0]    ovf;

    assign op    = op_e'(in_flat[IN_OP_LSB +: 3]);
    assign en    = in_flat[IN_EN_LSB +: LANES];
    assign shamt = in_flat[IN_SH_LSB +: 3];
    assign clr   = in_flat[IN_CLR_BIT];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_accum_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (in_flat[i*DW +: DW]),
            .op    (op),
            .en    (en[i]),
            .shamt (shamt),
            .clr   (clr),
            .acc   (acc_all[i*AW +: AW]),
            .ovf   (ovf[i])
        );
    end

    assign out_flat = {^acc_all, |acc_all, ovf, acc_all};

endmodule

// File: tb/tb_lane_accum_array.sv
// tb_lane_accum_array
//   Randomized and directed stimulus against a signed-arithmetic reference
//   model of the eight accumulator lanes.
module tb_lane_accum_array;

    logic         clk;
    logic         rst_n;
    logic [270:0] in_flat;
    logic [329:0] out_flat;

    lane_accum_array dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_flat  (in_flat),
        .out_flat (out_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus fields
    logic [31:0] a_v [8];
    logic [2:0]  op_v;
    logic [7:0]  en_v;
    logic [2:0]  sh_v;
    logic        clr_v;

    // reference model
    logic [39:0] m_acc [8];
    bit          m_ovf [8];

    localparam longint MAX40 = 64'sd549755813887;   //  2^39 - 1
    localparam longint MIN40 = -64'sd549755813888;  // -2^39

    task automatic drive();
        for (int i = 0; i < 8; i++) in_flat[i*32 +: 32] = a_v[i];
        in_flat[258:256] = op_v;
        in_flat[266:259] = en_v;
        in_flat[269:267] = sh_v;
        in_flat[270]     = clr_v;
    endtask

    task automatic set_all(input logic [31:0] a, input logic [2:0] op,
                           input logic [7:0] en, input logic [2:0] sh,
                           input logic clr);
        for (int i = 0; i < 8; i++) a_v[i] = a;
        op_v = op; en_v = en; sh_v = sh; clr_v = clr;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_acc[i] = '0;
            m_ovf[i] = 1'b0;
        end
    endfunction

    // Signed results are computed exactly in 64 bits, then range-checked
    // against the 40-bit window and wrapped.
    function automatic void model_step();
        longint acc_s, a_s, r;
        for (int i = 0; i < 8; i++) begin
            if (clr_v) begin
                m_acc[i] = '0;
                m_ovf[i] = 1'b0;
            end else if (en_v[i]) begin
                acc_s = longint'($signed(m_acc[i]));
                a_s   = longint'($signed(a_v[i]));
                r     = 0;
                case (op_v)
                    3'd0, 3'd1, 3'd6: begin
                        if (op_v == 3'd0)      r = acc_s + a_s;
                        else if (op_v == 3'd1) r = acc_s - a_s;
                        else                   r = acc_s + a_s * (64'sd1 << sh_v);
                        if (r > MAX40 || r < MIN40) m_ovf[i] = 1'b1;
                        m_acc[i] = r[39:0];
                    end
                    3'd2: m_acc[i] = m_acc[i] ^ {8'h00, a_v[i]};
                    3'd3: m_acc[i] = a_s[39:0];
                    3'd4: m_acc[i] = m_acc[i] & {8'h00, a_v[i]};
                    3'd5: m_acc[i] = m_acc[i] | {8'h00, a_v[i]};
                    default: ;
                endcase
            end
        end
    endfunction

    function automatic logic [329:0] expected();
        logic [329:0] e;
        logic [319:0] all;
        for (int i = 0; i < 8; i++) begin
            all[i*40 +: 40] = m_acc[i];
            e[320 + i]      = m_ovf[i];
        end
        e[319:0] = all;
        e[328]   = (all != '0);
        e[329]   = ^all;
        return e;
    endfunction

    function automatic logic [39:0] acc_of(input int i);
        return out_flat[i*40 +: 40];
    endfunction

    // One clock: present stimulus, advance model on the edge, settle 1ns.
    task automatic step();
        drive();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_all(32'h0, 3'd7, 8'h00, 3'd0, 1'b0);
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_flat !== 330'b0) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected 0", out_flat);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_hold_idle();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) a_v[i] = $urandom;
            op_v = 3'd7; en_v = 8'hFF; sh_v = 3'($urandom); clr_v = 1'b0;
            step();
            n_checks++;
            if (out_flat !== 330'b0) begin
                n_errors++;
                $display("FAIL hold_idle[%0d]: got %h expected 0", c, out_flat);
            end
        end
    endtask

    task automatic test_load_add();
        set_all(32'h0, 3'd3, 8'h01, 3'd0, 1'b0);
        a_v[0] = 32'h5;
        step();
        n_checks++;
        if (acc_of(0) !== 40'd5 || out_flat !== expected()) begin
            n_errors++;
            $display("FAIL load_lane0: got %h expected %h", out_flat, expected());
        end
        op_v = 3'd0; a_v[0] = 32'h3;
        step();
        n_checks++;
        if (acc_of(0) !== 40'd8 || out_flat[319:40] !== '0 ||
            out_flat[328] !== 1'b1 || out_flat[329] !== 1'b1) begin
            n_errors++;
            $display("FAIL add_lane0: got %h expected acc0=8 nz=1 par=1", out_flat);
        end
    endtask

    task automatic test_sub();
        set_all(32'h0, 3'd3, 8'h08, 3'd0, 1'b0);
        a_v[3] = 32'h8000_0000;
        step();
        n_checks++;
        if (acc_of(3) !== 40'hFF_8000_0000 || out_flat !== expected()) begin
            n_errors++;
            $display("FAIL load_neg_lane3: got %h expected %h", out_flat, expected());
        end
        op_v = 3'd1; a_v[3] = 32'h1;
        step();
        n_checks++;
        if (acc_of(3) !== 40'hFF_7FFF_FFFF || out_flat[323] !== 1'b0 ||
            out_flat !== expected()) begin
            n_errors++;
            $display("FAIL sub_lane3: got %h expected %h", out_flat, expected());
        end
    endtask

    task automatic test_overflow();
        bit flipped = 1'b0;
        set_all(32'h7FFF_FFFF, 3'd3, 8'h20, 3'd0, 1'b0);
        step();
        op_v = 3'd6; sh_v = 3'd7;
        for (int k = 0; k < 16 && !flipped; k++) begin
            step();
            n_checks++;
            if (out_flat !== expected()) begin
                n_errors++;
                $display("FAIL shadd_step[%0d]: got %h expected %h", k, out_flat, expected());
            end
            flipped = acc_of(5)[39];
        end
        n_checks++;
        if (!flipped || out_flat[325] !== 1'b1) begin
            n_errors++;
            $display("FAIL shadd_ovf: got ovf=%b flipped=%0d expected ovf=1", out_flat[327:320], flipped);
        end
        op_v = 3'd7;
        step();
        n_checks++;
        if (out_flat[325] !== 1'b1 || out_flat !== expected()) begin
            n_errors++;
            $display("FAIL ovf_sticky: got %h expected %h", out_flat, expected());
        end
        clr_v = 1'b1; op_v = 3'd0; en_v = 8'h00;
        step();
        clr_v = 1'b0;
        n_checks++;
        if (out_flat !== 330'b0) begin
            n_errors++;
            $display("FAIL clr: got %h expected 0", out_flat);
        end
    endtask

    task automatic test_mask_and();
        set_all(32'hFFFF_FFFF, 3'd3, 8'hFF, 3'd0, 1'b0);
        step();
        set_all(32'h0000_00FF, 3'd4, 8'hAA, 3'd0, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (acc_of(i) !== ((i % 2) ? 40'h00_0000_00FF : 40'hFF_FFFF_FFFF)) begin
                n_errors++;
                $display("FAIL mask_and lane%0d: got %h", i, acc_of(i));
            end
        end
        n_checks++;
        if (out_flat !== expected()) begin
            n_errors++;
            $display("FAIL mask_and_bus: got %h expected %h", out_flat, expected());
        end
    endtask

    task automatic test_negedge_sample();
        set_all(32'h0, 3'd3, 8'hFF, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) a_v[i] = $urandom;
        step();
        for (int i = 0; i < 8; i++) a_v[i] = $urandom;
        op_v = 3'd2;
        @(negedge clk);
        drive();
        #1;
        n_checks++;
        if (out_flat !== expected()) begin
            n_errors++;
            $display("FAIL negedge_no_effect: got %h expected %h", out_flat, expected());
        end
        @(posedge clk);
        model_step();
        #1;
        n_checks++;
        if (out_flat !== expected()) begin
            n_errors++;
            $display("FAIL negedge_next_edge: got %h expected %h", out_flat, expected());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 8; i++) a_v[i] = $urandom;
            op_v  = 3'($urandom);
            en_v  = 8'($urandom);
            sh_v  = 3'($urandom);
            clr_v = ($urandom_range(0, 15) == 0);
            step();
            n_checks++;
            if (out_flat !== expected()) begin
                n_errors++;
                if (bad < 5)
                    $display("FAIL random[%0d] op=%0d en=%h: got %h expected %h", c, op_v, en_v, out_flat, expected());
                bad++;
            end
        end
    endtask

    task automatic test_async_reset();
        set_all(32'h1234_5679, 3'd3, 8'hFF, 3'd0, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out_flat !== 330'b0) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected 0", out_flat);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_flat !== 330'b0) begin
            n_errors++;
            $display("FAIL reset_held: got %h expected 0", out_flat);
        end
        #2;
        rst_n = 1'b1;
        set_all(32'h0000_0011, 3'd0, 8'h81, 3'd0, 1'b0);
        step();
        n_checks++;
        if (acc_of(0) !== 40'h11 || acc_of(7) !== 40'h11 || out_flat !== expected()) begin
            n_errors++;
            $display("FAIL post_reset_update: got %h expected %h", out_flat, expected());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hold_idle();
        test_load_add();
        test_sub();
        test_overflow();
        test_mask_and();
        test_negedge_sample();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
